control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 143 ++++++++++++++
 tb/tb_control_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: four-state (IDLE/READ/EXEC/WB) controller that fetches one
// instruction, reads two operands from an external register bank, runs a
// small ALU and writes the result back. Fixed 4-cycle latency, no hazards.
module control_unit #(
    parameter int OPW = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [3:0]  address_a,
    output logic [3:0]  address_b,
    input  logic [15:0] data_out_a,
    input  logic [15:0] data_out_b,
    output logic        write_enable,
    output logic [3:0]  address_w,
    output logic [15:0] data_in_w,
    output logic        clear,
    output logic        done,
    output logic        illegal_op,
    output logic        zero_flag,
    output logic        carry_flag
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [OPW-1:0] OP_NOP   = 4'h0;
    localparam logic [OPW-1:0] OP_LOADI = 4'h1;
    localparam logic [OPW-1:0] OP_ADD   = 4'h2;
    localparam logic [OPW-1:0] OP_SUB   = 4'h3;
    localparam logic [OPW-1:0] OP_AND   = 4'h4;
    localparam logic [OPW-1:0] OP_OR    = 4'h5;
    localparam logic [OPW-1:0] OP_MOV   = 4'h6;
    localparam logic [OPW-1:0] OP_CLR   = 4'h7;

    state_t         state, state_nxt;
    logic [15:0]    ir;
    logic [15:0]    op_a, op_b;
    logic [15:0]    result;
    logic [OPW-1:0] opcode;
    logic [16:0]    sum17;
    logic [15:0]    alu_res;
    logic           alu_z, alu_c, alu_upd;
    logic           writes_reg;

    assign opcode    = ir[15:12];
    assign address_a = ir[7:4];
    assign address_b = ir[3:0];
    assign address_w = ir[11:8];
    assign data_in_w = result;
    assign sum17     = {1'b0, op_a} + {1'b0, op_b};

    // LOADI..MOV are the only opcodes that produce a register write
    assign writes_reg = (opcode >= OP_LOADI) && (opcode <= OP_MOV);

    // state register, instruction capture, operand/result/flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ir         <= '0;
            op_a       <= '0;
            op_b       <= '0;
            result     <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && instr_valid)
                ir <= instr;
            if (state == READ) begin
                op_a <= data_out_a;
                op_b <= data_out_b;
            end
            if (state == EXEC) begin
                result <= alu_res;
                if (alu_upd) begin
                    zero_flag  <= alu_z;
                    carry_flag <= alu_c;
                end
            end
        end
    end

    // ALU: result and flag update for the captured opcode
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_upd = 1'b0;
        case (opcode)
            OP_LOADI: alu_res = {8'h00, ir[7:0]};
            OP_ADD: begin
                alu_res = sum17[15:0];
                alu_c   = sum17[16];
                alu_upd = 1'b1;
            end
            OP_SUB: begin
                alu_res = op_a - op_b;
                alu_c   = (op_a >= op_b);
                alu_upd = 1'b1;
            end
            OP_AND: begin
                alu_res = op_a & op_b;
                alu_upd = 1'b1;
            end
            OP_OR: begin
                alu_res = op_a | op_b;
                alu_upd = 1'b1;
            end
            OP_MOV:  alu_res = op_a;
            default: alu_res = '0;
        endcase
        alu_z = (alu_res == 16'h0000);
    end

    // next state and per-state strobes; reset gates the handshake
    always_comb begin
        state_nxt    = state;
        instr_ready  = 1'b0;
        write_enable = 1'b0;
        clear        = 1'b0;
        done         = 1'b0;
        illegal_op   = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = ~reset;
                if (instr_valid)
                    state_nxt = READ;
            end
            READ: state_nxt = EXEC;
            EXEC: state_nxt = WB;
            WB: begin
                done         = 1'b1;
                write_enable = writes_reg;
                clear        = (opcode == OP_CLR);
                illegal_op   = (opcode > OP_CLR);
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: drives directed and random instruction streams into
// control_unit backed by a simple register bank, and checks every strobe,
// flag and bank value against a spec-level instruction model.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  address_a, address_b, address_w;
    logic [15:0] data_out_a, data_out_b, data_in_w;
    logic        write_enable, clear, done, illegal_op, zero_flag, carry_flag;

    int vectors = 0;
    int miscompares = 0;

    // register bank seen by the DUT
    logic [15:0] bank [16];
    // model of what the bank and flags should hold
    int mreg [16];
    int mz, mc;

    always #5 clk = ~clk;

    control_unit #(.OPW(4)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .address_a(address_a), .address_b(address_b),
        .data_out_a(data_out_a), .data_out_b(data_out_b),
        .write_enable(write_enable), .address_w(address_w), .data_in_w(data_in_w),
        .clear(clear), .done(done), .illegal_op(illegal_op),
        .zero_flag(zero_flag), .carry_flag(carry_flag)
    );

    assign data_out_a = bank[address_a];
    assign data_out_b = bank[address_b];

    always @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < 16; i++) bank[i] <= '0;
        end else if (write_enable) begin
            bank[address_w] <= data_in_w;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mreg[i] = 0;
        mz = 0;
        mc = 0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_we"}, write_enable, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_clr"}, clear, 0);
        chk({tag, "_ill"}, illegal_op, 0);
    endtask

    // issue one instruction (called at a negedge) and follow it to retirement;
    // keep leaves instr_valid high so the next handshake is back-to-back
    task automatic run_instr(input logic [15:0] ins, input bit keep);
        int w = 0;
        int op, rd, a, b, res, nz, nc, s;
        bit ewe, eclr, eill;
        instr_valid = 1'b1;
        instr = ins;
        while (!instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", w < 20, 1);
        op = ins[15:12]; rd = ins[11:8];
        a = mreg[ins[7:4]]; b = mreg[ins[3:0]];
        ewe = 0; eclr = 0; eill = 0; res = 0; nz = mz; nc = mc;
        case (op)
            1: begin ewe = 1; res = ins[7:0]; end
            2: begin ewe = 1; s = a + b; res = s % 65536; nc = (s > 65535); nz = (res == 0); end
            3: begin ewe = 1; res = (a - b + 65536) % 65536; nc = (a >= b); nz = (res == 0); end
            4: begin ewe = 1; res = a & b; nc = 0; nz = (res == 0); end
            5: begin ewe = 1; res = a | b; nc = 0; nz = (res == 0); end
            6: begin ewe = 1; res = a; end
            7: eclr = 1;
            0: ;
            default: eill = 1;
        endcase
        @(posedge clk);
        @(negedge clk);                 // READ
        if (!keep) instr_valid = 1'b0;
        instr = 16'($urandom);
        chk_quiet("read");
        chk("read_rdy", instr_ready, 0);
        @(negedge clk);                 // EXEC
        instr = 16'($urandom);
        chk_quiet("exec");
        @(negedge clk);                 // WB
        chk("wb_done", done, 1);
        chk("wb_we", write_enable, ewe);
        chk("wb_clr", clear, eclr);
        chk("wb_ill", illegal_op, eill);
        if (ewe) begin
            chk("wb_addr", address_w, rd);
            chk("wb_data", data_in_w, res);
        end
        chk("wb_z", zero_flag, nz);
        chk("wb_c", carry_flag, nc);
        if (ewe) mreg[rd] = res;
        if (eclr) for (int i = 0; i < 16; i++) mreg[i] = 0;
        mz = nz;
        mc = nc;
        @(negedge clk);                 // back in IDLE
        chk("idle_rdy", instr_ready, 1);
        chk_quiet("idle");
        if (ewe) chk("bank_rd", bank[rd], mreg[rd]);
    endtask

    task automatic chk_bank(input string tag);
        for (int i = 0; i < 16; i++) chk(tag, bank[i], mreg[i]);
    endtask

    function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int rs2);
        return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", instr_ready, 0);
        chk_quiet("rst");
        chk("rst_z", zero_flag, 0);
        chk("rst_c", carry_flag, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_rdy", instr_ready, 1);

        // LOADI r3 = 0xA5
        run_instr({4'h1, 4'd3, 8'hA5}, 0);
        // R1 = 0xFFFF (0 - 1), R2 = 1, ADD r4
        run_instr({4'h1, 4'd2, 8'h01}, 0);
        run_instr(mk(3, 1, 0, 2), 0);
        run_instr(mk(2, 4, 1, 2), 0);
        chk("add_z", zero_flag, 1);
        chk("add_c", carry_flag, 1);
        // R1 = 3, R2 = 5, SUB r1 (rd == rs1)
        run_instr({4'h1, 4'd1, 8'h03}, 0);
        run_instr({4'h1, 4'd2, 8'h05}, 0);
        run_instr(mk(3, 1, 1, 2), 0);
        chk("sub_r1", bank[1], 16'hFFFE);
        // undefined opcode, then CLR
        run_instr(mk(12, 5, 1, 2), 0);
        run_instr(mk(7, 0, 0, 0), 0);
        chk_bank("clr_bank");

        // reset arriving during EXEC of an ADD that would set flags
        run_instr({4'h1, 4'd1, 8'hFF}, 0);
        run_instr({4'h1, 4'd2, 8'h01}, 0);
        run_instr(mk(2, 3, 1, 2), 0);
        instr_valid = 1'b1;
        instr = mk(2, 4, 1, 1);
        @(posedge clk);
        @(negedge clk);                 // READ
        instr_valid = 1'b0;
        @(negedge clk);                 // EXEC
        reset = 1'b1;
        @(negedge clk);
        chk_quiet("abort");
        chk("abort_z", zero_flag, 0);
        chk("abort_c", carry_flag, 0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("abort_rdy", instr_ready, 1);
        chk_quiet("abort2");
        chk_bank("abort_bank");

        // instr_valid held high: back-to-back dependent ADDs
        run_instr({4'h1, 4'd1, 8'h01}, 1);
        for (int k = 0; k < 5; k++) run_instr(mk(2, 1, 1, 1), 1);
        run_instr(mk(2, 2, 1, 1), 0);
        chk("chain_r1", bank[1], 16'h0020);

        // random instruction mix
        for (int k = 0; k < 60; k++)
            run_instr(16'($urandom), (k != 59) && ($urandom_range(0, 1) == 1));
        chk_bank("final_bank");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
